stage_mem: RTL and testbench
============================

Name: stage_mem

Overview:
Memory-access stage of the 5-stage RISC-V pipeline. It sits directly downstream of the execute stage, taking the ULA result as the address and the forwarded rs2 value as store data. It drives a single-port data-memory bus with a req/ready handshake and generates byte enables and store-lane replication. It sign/zero-extends load data and holds the pipeline via a stall output until the access completes.

Parameters:
TIMEOUT_CYCLES, 0, maximum cycles spent in WAIT before aborting with a fault; 0 disables the timeout.
CNT_W, 8, width of the timeout counter; must satisfy 2^CNT_W > TIMEOUT_CYCLES.

Ports:
clk  input  1  pipeline clock, rising edge
reset  input  1  asynchronous, active-high reset
mem_read  input  1  current MEM instruction is a load
mem_write  input  1  current MEM instruction is a store (mem_read and mem_write never both 1)
funct3  input  3  access size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU
addr  input  32  byte address (ULA result from the EX/MEM register)
store_data  input  32  rs2 value after forwarding
dmem_req  output  1  bus request
dmem_we  output  1  1 = write
dmem_addr  output  32  word address: {addr[31:2],2'b00}
dmem_wdata  output  32  lane-replicated store data
dmem_be  output  4  byte enables
dmem_rdata  input  32  read word; valid when dmem_ready=1
dmem_ready  input  1  completes the request in the same cycle
load_data  output  32  extended load result for MEM/WB
mem_stall  output  1  freeze PC, IF/ID, ID/EX and EX/MEM
mem_fault  output  1  misaligned address, illegal funct3, or timeout

Behaviour:
- Reset values: state IDLE, load_data 0, mem_fault 0, timeout counter 0; dmem_req low immediately (asynchronous).
- access = mem_read | mem_write. ok = legal funct3 and natural alignment.
  - Halfword needs addr[0]=0; word needs addr[1:0]=00.
  - Legal funct3 for loads: 000, 001, 010, 100, 101. For stores: 000, 001, 010.
- FSM states: IDLE, WAIT, DONE.
  - IDLE, access & ok: drive dmem_req=1 and mem_stall=1 combinationally. If dmem_ready=1 in the same cycle, go DONE; otherwise go WAIT.
  - IDLE, access & !ok: no request and no stall. Assert mem_fault (registered) for exactly 1 cycle; load_data <= 0.
  - WAIT: dmem_req=1, mem_stall=1, counter increments each cycle. dmem_ready=1 goes to DONE.
  - WAIT timeout: if TIMEOUT_CYCLES!=0 and counter==TIMEOUT_CYCLES-1 without ready, go DONE with mem_fault=1 and load_data=0.
  - DONE: dmem_req=0, mem_stall=0, so the pipeline advances at the end of this cycle. Next state is always IDLE. The same instruction is never re-issued.
- Minimum access latency: 2 cycles (request + DONE). Each extra cycle in WAIT adds one.
- dmem_ready is ignored whenever dmem_req=0.
- Bus outputs (dmem_addr, dmem_we, dmem_be, dmem_wdata) are held stable while dmem_req=1.
- Load capture: on the ready cycle, load_data <= extend(dmem_rdata, addr[1:0], funct3).
  - Byte lane = addr[1:0]; half lane = addr[1].
  - funct3 000/001 sign-extend; 100/101 zero-extend.
  - For stores, load_data <= 0.
- Store lanes:
  - SB: be = 4'b0001<<addr[1:0], wdata = {4{sd[7:0]}}.
  - SH: be = addr[1] ? 1100 : 0011, wdata = {2{sd[15:0]}}.
  - SW: be = 1111, wdata = sd.
  - Loads: be = 1111, dmem_we = 0.
- load_data and mem_fault are registered and change only on the transition into DONE or on a fault cycle. They are otherwise held.
- Reset mid-WAIT: the request is abandoned and the bus must drop it. Back in IDLE, the instruction is re-seen only if it is still present.

Decomposition:
- Package riscv_mem_pkg holds:
  - funct3 constants F3_B, F3_H, F3_W, F3_BU, F3_HU;
  - the state encoding IDLE=2'd0, WAIT=2'd1, DONE=2'd2.
- One combinational sub-module, load_align (rdata, byte_off, funct3 -> 32-bit extended value), reused by the bench as the reference model.

Test Plan:
1. LW addr=0x100, ready in the request cycle, rdata=0xDEADBEEF -> dmem_be=1111; stall for 1 cycle; load_data=0xDEADBEEF in DONE.
2. LB addr=0x103, rdata=0x80FF0000, ready after 3 WAIT cycles -> stall for 4 cycles; load_data=0xFFFFFF80. Repeat with LBU -> 0x00000080.
3. SH addr=0x202, store_data=0x1234ABCD -> dmem_we=1, be=1100, wdata=0xABCDABCD, dmem_addr=0x200; load_data=0.
4. LW addr=0x101 -> no dmem_req, no stall; mem_fault=1 for exactly 1 cycle; load_data=0.
5. TIMEOUT_CYCLES=4, LW with ready never asserted -> WAIT lasts 4 cycles, then DONE with mem_fault=1 and load_data=0; stall releases.
6. Reset asserted during WAIT -> dmem_req=0 immediately; mem_stall=0; load_data=0; FSM in IDLE after release.

Source files
------------

// File: rtl/riscv_mem_pkg.sv
// Shared constants and helpers for the memory-access stage.
// Covers funct3 access sizes, FSM encoding and legality checks.
package riscv_mem_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] WAIT = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  function automatic logic f3_ok(
    input logic [2:0] f3,
    input logic       st
  );
    logic r;
    if (st)
      r = f3 inside {F3_B, F3_H, F3_W};
    else
      r = f3 inside {F3_B, F3_H, F3_W, F3_BU, F3_HU};
    return r;
  endfunction

  function automatic logic aligned(
    input logic [2:0] f3,
    input logic [1:0] off
  );
    logic r;
    case (f3[1:0])
      2'b00:   r = 1'b1;
      2'b01:   r = ~off[0];
      2'b10:   r = (off == 2'b00);
      default: r = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/load_align.sv
// Picks the addressed byte/half out of a bus word and extends it.
// Unused funct3 codes pass the word through.
module load_align
  import riscv_mem_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  byte_off,
  input  logic [2:0]  funct3,
  output logic [31:0] value
);

  logic [7:0]  b;
  logic [15:0] h;

  always_comb begin
    b = rdata[{byte_off, 3'b000} +: 8];
    h = byte_off[1] ? rdata[31:16] : rdata[15:0];
    value = rdata;
    unique case (1'b1)
      (funct3 == F3_B):  value = {{24{b[7]}}, b};
      (funct3 == F3_H):  value = {{16{h[15]}}, h};
      (funct3 == F3_BU): value = {24'd0, b};
      (funct3 == F3_HU): value = {16'd0, h};
      default:           value = rdata;
    endcase
  end

endmodule

// File: rtl/stage_mem.sv
// MEM stage: req/ready data-memory master with lane steering,
// load extension, pipeline stall and fault/timeout reporting.
module stage_mem
  import riscv_mem_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 0,
  parameter int CNT_W          = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  input  logic [31:0] store_data,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  output logic [3:0]  dmem_be,
  input  logic [31:0] dmem_rdata,
  input  logic        dmem_ready,
  output logic [31:0] load_data,
  output logic        mem_stall,
  output logic        mem_fault
);

  localparam int TO_M1 =
    (TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0;
  localparam logic [CNT_W-1:0] TO_LAST = TO_M1[CNT_W-1:0];
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [1:0]       state, state_nx;
  logic [CNT_W-1:0] cnt;
  logic             access, ok;
  logic             ready_hit, tmo, fault_evt;
  logic [31:0]      ext;

  assign access    = mem_read | mem_write;
  assign ok        = f3_ok(funct3, mem_write)
                   & aligned(funct3, addr[1:0]);
  assign fault_evt = (state == IDLE) & access & ~ok;
  assign ready_hit = dmem_req & dmem_ready;
  assign tmo       = (TIMEOUT_CYCLES != 0) & (state == WAIT)
                   & (cnt == TO_LAST) & ~dmem_ready;

  // Gated by reset so an abandoned request drops without a clock.
  assign dmem_req  = ~reset & (((state == IDLE) & access & ok)
                   | (state == WAIT));
  assign mem_stall = dmem_req;
  assign dmem_we   = mem_write;
  assign dmem_addr = {addr[31:2], 2'b00};

  always_comb begin
    dmem_be    = 4'b1111;
    dmem_wdata = store_data;
    unique case (1'b1)
      (mem_write && funct3 == F3_B): begin
        dmem_be    = 4'b0001 << addr[1:0];
        dmem_wdata = {4{store_data[7:0]}};
      end
      (mem_write && funct3 == F3_H): begin
        dmem_be    = addr[1] ? 4'b1100 : 4'b0011;
        dmem_wdata = {2{store_data[15:0]}};
      end
      default: begin
        dmem_be    = 4'b1111;
        dmem_wdata = store_data;
      end
    endcase
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: if (access && ok)
              state_nx = dmem_ready ? DONE : WAIT;
      WAIT: if (dmem_ready || tmo)
              state_nx = DONE;
      DONE: state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  load_align u_align (
    .rdata    (dmem_rdata),
    .byte_off (addr[1:0]),
    .funct3   (funct3),
    .value    (ext)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      cnt       <= '0;
      load_data <= '0;
      mem_fault <= 1'b0;
    end else begin
      state     <= state_nx;
      cnt       <= (state == WAIT) ? cnt + CNT_ONE : '0;
      mem_fault <= fault_evt | tmo;
      if (fault_evt || tmo)
        load_data <= '0;
      else if (ready_hit)
        load_data <= mem_write ? 32'd0 : ext;
    end
  end

endmodule

// File: tb/tb_stage_mem.sv
// Directed plus random checks of stage_mem against an
// arithmetic reference of the access rules.
module tb_stage_mem;

  localparam int T = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        mem_read = 1'b0;
  logic        mem_write = 1'b0;
  logic [2:0]  funct3 = 3'd0;
  logic [31:0] addr = 32'd0;
  logic [31:0] store_data = 32'd0;
  logic        dmem_req, dmem_we;
  logic [31:0] dmem_addr, dmem_wdata;
  logic [3:0]  dmem_be;
  logic [31:0] dmem_rdata = 32'd0;
  logic        dmem_ready = 1'b0;
  logic [31:0] load_data;
  logic        mem_stall, mem_fault;

  int total = 0;
  int bad = 0;
  logic [31:0] exp_ld = 32'd0;

  always #5 clk = ~clk;

  stage_mem #(.TIMEOUT_CYCLES(T), .CNT_W(8)) dut (
    .clk        (clk),
    .reset      (reset),
    .mem_read   (mem_read),
    .mem_write  (mem_write),
    .funct3     (funct3),
    .addr       (addr),
    .store_data (store_data),
    .dmem_req   (dmem_req),
    .dmem_we    (dmem_we),
    .dmem_addr  (dmem_addr),
    .dmem_wdata (dmem_wdata),
    .dmem_be    (dmem_be),
    .dmem_rdata (dmem_rdata),
    .dmem_ready (dmem_ready),
    .load_data  (load_data),
    .mem_stall  (mem_stall),
    .mem_fault  (mem_fault)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic bit legal(input bit wr, input logic [2:0] f3,
                               input logic [31:0] a);
    int sz;
    if (wr && !(f3 inside {3'd0, 3'd1, 3'd2})) return 0;
    if (!(f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5})) return 0;
    sz = 1 << f3[1:0];
    return (a % sz) == 0;
  endfunction

  function automatic logic [31:0] ref_ext(input logic [31:0] w,
      input logic [1:0] off, input logic [2:0] f3);
    logic [31:0] b, h;
    b = (w >> (8 * off)) & 32'hff;
    h = (w >> (16 * off[1])) & 32'hffff;
    case (f3)
      3'd0: return (b >= 128) ? b - 32'd256 : b;
      3'd1: return (h >= 32768) ? h - 32'd65536 : h;
      3'd4: return b;
      3'd5: return h;
      default: return w;
    endcase
  endfunction

  function automatic logic [3:0] ref_be(input bit wr,
      input logic [2:0] f3, input logic [1:0] off);
    if (!wr || f3 == 3'd2) return 4'hf;
    if (f3 == 3'd0) return 4'(1 << off);
    return 4'(3 << (off & 2'b10));
  endfunction

  function automatic logic [31:0] ref_wd(input logic [2:0] f3,
      input logic [31:0] sd);
    if (f3 == 3'd0) return sd[7:0] * 32'h01010101;
    if (f3 == 3'd1) return sd[15:0] * 32'h00010001;
    return sd;
  endfunction

  // r = cycle index (0 = request cycle) on which ready rises.
  task automatic run(input bit rd, input bit wr, input logic [2:0] f3,
                     input logic [31:0] a, input logic [31:0] sd,
                     input logic [31:0] rw, input int r);
    int nst;
    bit to;
    if (!legal(wr, f3, a)) begin
      @(negedge clk);
      mem_read = rd; mem_write = wr; funct3 = f3;
      addr = a; store_data = sd;
      dmem_ready = 1'($urandom_range(0, 1));
      #1;
      chk("flt_req", 32'(dmem_req), 0);
      chk("flt_stall", 32'(mem_stall), 0);
      @(negedge clk);
      mem_read = 0; mem_write = 0; dmem_ready = 0;
      #1;
      exp_ld = 0;
      chk("flt_pulse", 32'(mem_fault), 1);
      chk("flt_ld", load_data, 0);
      @(negedge clk);
      #1;
      chk("flt_clear", 32'(mem_fault), 0);
      return;
    end
    to = r > T;
    nst = to ? T + 1 : r + 1;
    for (int i = 0; i < nst; i++) begin
      @(negedge clk);
      mem_read = rd; mem_write = wr; funct3 = f3;
      addr = a; store_data = sd;
      dmem_ready = (i == r);
      dmem_rdata = (i == r) ? rw : $urandom;
      #1;
      chk("req", 32'(dmem_req), 1);
      chk("stall", 32'(mem_stall), 1);
      chk("we", 32'(dmem_we), 32'(wr));
      chk("baddr", dmem_addr, a & 32'hffff_fffc);
      chk("be", 32'(dmem_be), 32'(ref_be(wr, f3, a[1:0])));
      if (wr) chk("wdata", dmem_wdata, ref_wd(f3, sd));
      chk("ld_hold", load_data, exp_ld);
    end
    @(negedge clk);
    dmem_ready = 1'($urandom_range(0, 1));
    dmem_rdata = $urandom;
    #1;
    exp_ld = (to || wr) ? 32'd0 : ref_ext(rw, a[1:0], f3);
    chk("done_req", 32'(dmem_req), 0);
    chk("done_stall", 32'(mem_stall), 0);
    chk("done_ld", load_data, exp_ld);
    chk("done_flt", 32'(mem_fault), 32'(to));
    @(negedge clk);
    mem_read = 0; mem_write = 0; dmem_ready = 0;
    #1;
    chk("after_flt", 32'(mem_fault), 0);
    chk("after_ld", load_data, exp_ld);
    chk("after_req", 32'(dmem_req), 0);
  endtask

  initial begin
    #1;
    chk("rst_req", 32'(dmem_req), 0);
    chk("rst_stall", 32'(mem_stall), 0);
    chk("rst_ld", load_data, 0);
    chk("rst_flt", 32'(mem_fault), 0);
    @(negedge clk);
    reset = 0;

    run(1, 0, 3'd2, 32'h100, 0, 32'hDEADBEEF, 0);
    chk("t1_ld", load_data, 32'hDEADBEEF);
    run(1, 0, 3'd0, 32'h103, 0, 32'h80FF0000, 3);
    chk("t2_lb", load_data, 32'hFFFFFF80);
    run(1, 0, 3'd4, 32'h103, 0, 32'h80FF0000, 3);
    chk("t2_lbu", load_data, 32'h00000080);
    run(0, 1, 3'd1, 32'h202, 32'h1234ABCD, 0, 0);
    run(1, 0, 3'd2, 32'h101, 0, 0, 0);
    run(1, 0, 3'd2, 32'h300, 0, 32'h5555AAAA, 1000);

    // reset while waiting
    run(1, 0, 3'd1, 32'h42, 0, 32'hA5A5F00F, 0);
    @(negedge clk);
    mem_read = 1; funct3 = 3'd2; addr = 32'h400; dmem_ready = 0;
    repeat (2) @(negedge clk);
    #1;
    chk("rw_req", 32'(dmem_req), 1);
    reset = 1;
    #1;
    exp_ld = 0;
    chk("rw_req_drop", 32'(dmem_req), 0);
    chk("rw_stall", 32'(mem_stall), 0);
    chk("rw_ld", load_data, 0);
    chk("rw_flt", 32'(mem_fault), 0);
    @(negedge clk);
    #1;
    chk("rw_hold_req", 32'(dmem_req), 0);
    @(negedge clk);
    reset = 0;
    #1;
    chk("rw_reseen", 32'(dmem_req), 1);
    mem_read = 0;
    #1;
    chk("rw_idle", 32'(dmem_req), 0);
    @(negedge clk);
    #1;
    chk("rw_idle2", 32'(dmem_req), 0);
    run(1, 0, 3'd5, 32'h402, 0, 32'h8001_7FFF, 2);

    for (int k = 0; k < 40; k++) begin
      bit wr;
      logic [2:0] f3;
      logic [31:0] a;
      wr = 1'($urandom_range(0, 1));
      f3 = ($urandom_range(0, 3) == 0) ? 3'($urandom_range(0, 7))
                                       : 3'($urandom_range(0, 2));
      if (!wr && $urandom_range(0, 2) == 0) f3[2] = 1'b1;
      a = $urandom;
      if ($urandom_range(0, 1) == 1) a[0] = 1'b0;
      if ($urandom_range(0, 1) == 1) a[1] = 1'b0;
      run(!wr, wr, f3, a, $urandom, $urandom,
          int'($urandom_range(0, 6)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
